mic1_cbus_regfile: RTL

//   Downstream stage of the Mic-1 ALU. Shifts the ALU result (SLL8/SRA1) and

---
 rtl/mic1_pkg.sv | 37 +++
 rtl/mic1_shifter.sv | 25 ++
 rtl/mic1_cbus_regfile.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mic1_pkg.sv
// Shared encodings for the Mic-1 C-bus / register-file stage: B-bus sources,
// C-mask bit positions and memory-control bit positions.
package mic1_pkg;

    localparam int DW = 32;

    // B-bus source encodings; values 9..15 select zero.
    typedef enum logic [3:0] {
        B_MDR  = 4'd0,
        B_PC   = 4'd1,
        B_MBR  = 4'd2,
        B_MBRU = 4'd3,
        B_SP   = 4'd4,
        B_LV   = 4'd5,
        B_CPP  = 4'd6,
        B_TOS  = 4'd7,
        B_OPC  = 4'd8
    } b_sel_e;

    // Bit positions within the 9-bit C-bus load mask.
    localparam int C_MAR = 0;
    localparam int C_MDR = 1;
    localparam int C_PC  = 2;
    localparam int C_SP  = 3;
    localparam int C_LV  = 4;
    localparam int C_CPP = 5;
    localparam int C_TOS = 6;
    localparam int C_OPC = 7;
    localparam int C_H   = 8;
    localparam int C_NUM = 9;

    // Bit positions within mem_ctl.
    localparam int MEM_FETCH = 0;
    localparam int MEM_RD    = 1;
    localparam int MEM_WR    = 2;

endpackage

// File: rtl/mic1_shifter.sv
// Combinational post-ALU shifter: SLL8 or SRA1; both at once is an illegal
// encoding and passes the value through untouched.
module mic1_shifter
    import mic1_pkg::*;
(
    input  logic [DW-1:0] x,
    input  logic          sll8,
    input  logic          sra1,
    output logic [DW-1:0] y,
    output logic          illegal
);

    always_comb begin
        y       = x;
        illegal = 1'b0;
        if (sll8 && sra1) begin
            illegal = 1'b1;
        end else if (sll8) begin
            y = {x[DW-9:0], 8'h00};
        end else if (sra1) begin
            y = {x[DW-1], x[DW-1:1]};
        end
    end

endmodule

// File: rtl/mic1_cbus_regfile.sv
// Mic-1 C-bus write-back stage: shifts the ALU result, loads the selected
// datapath registers, drives A/B buses and runs the memory/fetch handshakes.
module mic1_cbus_regfile #(
    parameter int          DW       = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_n,
    input  logic          alu_z,
    input  logic          sll8,
    input  logic          sra1,
    input  logic [8:0]    c_sel,
    input  logic [3:0]    b_sel,
    input  logic [2:0]    mem_ctl,
    input  logic          uinst_valid,
    output logic          stall,
    output logic [DW-1:0] a_bus,
    output logic [DW-1:0] b_bus,
    output logic          n_flag,
    output logic          z_flag,
    output logic          uop_err,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [DW-1:0] if_addr,
    output logic          if_req,
    input  logic [7:0]    if_data,
    input  logic          if_ack
);
    import mic1_pkg::*;

    logic [DW-1:0] creg_reg  [C_NUM];
    logic [DW-1:0] creg_next [C_NUM];
    logic [7:0]    mbr_reg;
    logic          n_reg, z_reg, err_reg;
    logic          pend_rd_reg, pend_wr_reg, pend_fetch_reg;

    logic [DW-1:0] c_val;
    logic          shift_illegal;
    logic          commit;
    logic          rdwr_clash;

    mic1_shifter u_shifter (
        .x       (alu_out),
        .sll8    (sll8),
        .sra1    (sra1),
        .y       (c_val),
        .illegal (shift_illegal)
    );

    assign stall      = pend_rd_reg | pend_wr_reg | pend_fetch_reg;
    assign commit     = uinst_valid & ~stall;
    assign rdwr_clash = mem_ctl[MEM_RD] & mem_ctl[MEM_WR];

    // Commit and acks never coincide: an ack only arrives while stalled.
    genvar gi;
    generate
        for (gi = 0; gi < C_NUM; gi++) begin : g_creg_next
            if (gi == C_MDR) begin : g_mdr
                assign creg_next[gi] = (commit && c_sel[gi])       ? c_val     :
                                       (mem_ack && pend_rd_reg)    ? mem_rdata :
                                                                     creg_reg[gi];
            end else begin : g_plain
                assign creg_next[gi] = (commit && c_sel[gi]) ? c_val : creg_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_NUM; i++) begin
                creg_reg[i] <= '0;
            end
            creg_reg[C_PC] <= RESET_PC[DW-1:0];
            mbr_reg        <= '0;
            n_reg          <= 1'b0;
            z_reg          <= 1'b0;
            err_reg        <= 1'b0;
            pend_rd_reg    <= 1'b0;
            pend_wr_reg    <= 1'b0;
            pend_fetch_reg <= 1'b0;
        end else begin
            for (int i = 0; i < C_NUM; i++) begin
                creg_reg[i] <= creg_next[i];
            end
            if (commit) begin
                n_reg          <= alu_n;
                z_reg          <= alu_z;
                pend_wr_reg    <= mem_ctl[MEM_WR];
                pend_rd_reg    <= mem_ctl[MEM_RD] & ~mem_ctl[MEM_WR];
                pend_fetch_reg <= mem_ctl[MEM_FETCH];
                if (shift_illegal || rdwr_clash) begin
                    err_reg <= 1'b1;
                end
            end else begin
                if (mem_ack) begin
                    pend_rd_reg <= 1'b0;
                    pend_wr_reg <= 1'b0;
                end
                if (if_ack && pend_fetch_reg) begin
                    mbr_reg        <= if_data;
                    pend_fetch_reg <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        b_bus = '0;
        case (b_sel_e'(b_sel))
            B_MDR:   b_bus = creg_reg[C_MDR];
            B_PC:    b_bus = creg_reg[C_PC];
            B_MBR:   b_bus = {{(DW-8){mbr_reg[7]}}, mbr_reg};
            B_MBRU:  b_bus = {{(DW-8){1'b0}}, mbr_reg};
            B_SP:    b_bus = creg_reg[C_SP];
            B_LV:    b_bus = creg_reg[C_LV];
            B_CPP:   b_bus = creg_reg[C_CPP];
            B_TOS:   b_bus = creg_reg[C_TOS];
            B_OPC:   b_bus = creg_reg[C_OPC];
            default: b_bus = '0;
        endcase
    end

    assign a_bus     = creg_reg[C_H];
    assign n_flag    = n_reg;
    assign z_flag    = z_reg;
    assign uop_err   = err_reg;
    assign mem_addr  = {creg_reg[C_MAR][DW-3:0], 2'b00};
    assign mem_wdata = creg_reg[C_MDR];
    assign mem_re    = pend_rd_reg;
    assign mem_we    = pend_wr_reg;
    assign if_addr   = creg_reg[C_PC];
    assign if_req    = pend_fetch_reg;

endmodule
